fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 155 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a burst of `len` words from a FIFO into a 2-entry output buffer
// and presents them downstream on a valid/ready handshake.
// FIRSTWORD_FALLTHROUGH selects whether FIFO data is valid alongside the read strobe (1)
// or one cycle after it (0).
// Optional: define FIFO_BURST_READER_COUNT_EN to add the word_count output.
module fifo_burst_reader #(
  parameter int unsigned WIDTH                 = 32,
  parameter bit          FIRSTWORD_FALLTHROUGH = 1'b1,
  parameter int unsigned LENW                  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dataout,
  output logic             fifo_read,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef FIFO_BURST_READER_COUNT_EN
  ,
  output logic [LENW-1:0]  word_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  localparam logic [LENW-1:0] LenOne = 1;

  state_e           state_q, state_d;
  logic [LENW-1:0]  remaining_q, remaining_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;  // oldest entry
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic             accept;
  logic [1:0]       occ_net;
  logic             wr_en;
`ifdef FIFO_BURST_READER_COUNT_EN
  logic [LENW-1:0]  count_q, count_d;
`endif

  // Read strobe, buffer update and next-state logic.
  always_comb begin
    out_valid = (occ_q != 2'd0);
    out_data  = buf0_q;
    accept    = out_valid && out_ready;
    // Occupancy net of this cycle's downstream accept, so a word leaving the buffer frees
    // its slot immediately; this is what sustains one word per cycle.
    occ_net   = occ_q - {1'b0, accept};
    fifo_read = (state_q == StRun) && (remaining_q != '0) && !fifo_empty &&
                ((occ_net + {1'b0, inflight_q}) < 2'd2);

    if (FIRSTWORD_FALLTHROUGH) begin
      wr_en      = fifo_read;
      inflight_d = 1'b0;
    end else begin
      wr_en      = inflight_q;
      inflight_d = fifo_read;
    end

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    if (accept) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (wr_en) begin
      if (occ_d == 2'd0) begin
        buf0_d = fifo_dataout;
      end else begin
        buf1_d = fifo_dataout;
      end
      occ_d = occ_d + 2'd1;
    end

    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d     = StRun;
            remaining_d = len;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (fifo_read) begin
          remaining_d = remaining_q - LenOne;
          if (remaining_q == LenOne) begin
            state_d = StFlush;
          end
        end
      end
      // Leave as soon as the last word is accepted so done follows it by one cycle.
      StFlush: begin
        if ((occ_d == 2'd0) && !inflight_d) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy = (state_q == StRun) || (state_q == StFlush);
    done = (state_q == StDone);
  end

`ifdef FIFO_BURST_READER_COUNT_EN
  // Accepted-word counter, cleared when a burst is accepted and held afterwards.
  always_comb begin
    count_d = count_q;
    if ((state_q == StIdle) && start) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + LenOne;
    end
    word_count = count_q;
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
`ifdef FIFO_BURST_READER_COUNT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
`ifdef FIFO_BURST_READER_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: drives a FWFT and a non-FWFT instance with identical bursts and
// checks both against a stream-level reference (expected word order, read count, done
// timing, busy window, hold-while-stalled, first-word latency).
module tb_fifo_burst_reader;
  localparam int W  = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, out_ready;
  logic [LW-1:0] len;
  logic          fe_ft, fe_nf;
  logic [W-1:0]  dout_ft, dout_nf;
  logic          fr_ft, fr_nf, ov_ft, ov_nf, bz_ft, bz_nf, dn_ft, dn_nf;
  logic [W-1:0]  od_ft, od_nf;
`ifdef FIFO_BURST_READER_COUNT_EN
  logic [LW-1:0] wc_ft, wc_nf;
`endif

  fifo_burst_reader #(.WIDTH(W), .FIRSTWORD_FALLTHROUGH(1'b1), .LENW(LW)) u_ft (
    .clk(clk), .reset(reset), .start(start), .len(len), .fifo_empty(fe_ft),
    .fifo_dataout(dout_ft), .fifo_read(fr_ft), .out_data(od_ft), .out_valid(ov_ft),
    .out_ready(out_ready), .busy(bz_ft), .done(dn_ft)
`ifdef FIFO_BURST_READER_COUNT_EN
    , .word_count(wc_ft)
`endif
  );

  fifo_burst_reader #(.WIDTH(W), .FIRSTWORD_FALLTHROUGH(1'b0), .LENW(LW)) u_nf (
    .clk(clk), .reset(reset), .start(start), .len(len), .fifo_empty(fe_nf),
    .fifo_dataout(dout_nf), .fifo_read(fr_nf), .out_data(od_nf), .out_valid(ov_nf),
    .out_ready(out_ready), .busy(bz_nf), .done(dn_nf)
`ifdef FIFO_BURST_READER_COUNT_EN
    , .word_count(wc_nf)
`endif
  );

  // Reference state, index 0 = FWFT instance, 1 = non-FWFT instance.
  logic [W-1:0] fq[2][$];
  logic [W-1:0] ex[2][$];
  bit           active[2], done_due[2], prev_stall[2], just_rst[2];
  int           blen[2], reads[2], deliv[2], first_rd[2], first_val[2];
  int           start_cyc[2], done_cyc[2];
  logic [W-1:0] prev_od[2];
  logic [W-1:0] nf_hold;
  bit           force_empty;
  int           cyc;
  int           n_vec, n_err;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit all_idle();
    return !active[0] && !done_due[0] && !active[1] && !done_due[1];
  endfunction

  task automatic push(logic [W-1:0] w);
    fq[0].push_back(w);
    fq[1].push_back(w);
  endtask

  task automatic drive_pins();
    fe_ft   = force_empty || (fq[0].size() == 0);
    dout_ft = (fq[0].size() != 0) ? fq[0][0] : 32'hDEAD_BEEF;
    fe_nf   = force_empty || (fq[1].size() == 0);
    dout_nf = nf_hold;
  endtask

  task automatic observe(int i, logic frv, logic ovv, logic bzv, logic dnv, logic fev,
                         logic [W-1:0] odv);
    string        s;
    bit           idle, acc, dd_next;
    logic [W-1:0] e;
    s       = (i == 0) ? "_ft" : "_nf";
    idle    = !active[i] && !done_due[i];
    acc     = ovv && out_ready;
    dd_next = 1'b0;
    if (just_rst[i]) begin
      check({"rst_outs", s}, {frv, ovv, bzv, dnv, odv}, '0);
      just_rst[i] = 1'b0;
    end
    check({"rd_empty", s}, frv & fev, 0);
    check({"rd_idle", s}, frv & !active[i], 0);
    check({"busy", s}, bzv, active[i]);
    check({"done", s}, dnv, done_due[i]);
    if (prev_stall[i]) check({"hold", s}, {ovv, odv}, {1'b1, prev_od[i]});
    prev_stall[i] = ovv && !out_ready;
    prev_od[i]    = odv;
    if (frv) begin
      reads[i]++;
      if (first_rd[i] < 0) first_rd[i] = cyc;
    end
    if (ovv && first_val[i] < 0) first_val[i] = cyc;
    if (acc) begin
      if (ex[i].size() == 0) begin
        check({"extra_word", s}, 1, 0);
      end else begin
        e = ex[i].pop_front();
        check({"data", s}, odv, e);
      end
      deliv[i]++;
      if (active[i] && deliv[i] == blen[i]) begin
        active[i] = 1'b0;
        dd_next   = 1'b1;
      end
    end
    if (done_due[i]) begin
      done_cyc[i] = cyc;
      check({"nreads", s}, reads[i], blen[i]);
      if (blen[i] > 0) check({"latency", s}, first_val[i] - first_rd[i], (i == 0) ? 1 : 2);
`ifdef FIFO_BURST_READER_COUNT_EN
      check({"word_count", s}, (i == 0) ? wc_ft : wc_nf, blen[i]);
`endif
    end
    if (idle && start) begin
      blen[i] = int'(len);
      ex[i].delete();
      for (int k = 0; k < int'(len) && k < fq[i].size(); k++) ex[i].push_back(fq[i][k]);
      reads[i]     = 0;
      deliv[i]     = 0;
      first_rd[i]  = -1;
      first_val[i] = -1;
      start_cyc[i] = cyc;
      if (len == '0) dd_next = 1'b1;
      else active[i] = 1'b1;
    end
    done_due[i] = dd_next;
  endtask

  // One clock cycle: check at the falling edge, advance the FIFO models after the rising edge.
  task automatic tick();
    bit rd[2];
    drive_pins();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rd[i] = (i == 0) ? fr_ft : fr_nf;
      if (reset) begin
        active[i]     = 1'b0;
        done_due[i]   = 1'b0;
        prev_stall[i] = 1'b0;
        just_rst[i]   = 1'b1;
        ex[i].delete();
      end else if (i == 0) begin
        observe(0, fr_ft, ov_ft, bz_ft, dn_ft, fe_ft, od_ft);
      end else begin
        observe(1, fr_nf, ov_nf, bz_nf, dn_nf, fe_nf, od_nf);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd[0] && fq[0].size() > 0) void'(fq[0].pop_front());
    if (rd[1] && fq[1].size() > 0) nf_hold = fq[1].pop_front();
    else nf_hold = $urandom();
    drive_pins();
  endtask

  task automatic wait_idle(int max, bit toggle);
    int k = 0;
    while (!all_idle() && k < max) begin
      if (toggle) force_empty = ~force_empty;
      tick();
      k++;
    end
    check("idle_timeout", all_idle(), 1);
    force_empty = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b1;
    force_empty = 1'b0; nf_hold = '0; cyc = 0; n_vec = 0; n_err = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Known data, full throughput.
    push(32'h9); push(32'h1); push(32'h2);
    start = 1'b1; len = 3; tick(); start = 1'b0;
    wait_idle(40, 1'b0);
    check("thruput_ft", done_cyc[0] - start_cyc[0], 5);
    check("thruput_nf", done_cyc[1] - start_cyc[1], 6);

    // Downstream stall for 5 cycles: reads stop once two words are buffered.
    repeat (4) push($urandom());
    start = 1'b1; len = 4; tick(); start = 1'b0;
    out_ready = 1'b0;
    repeat (5) tick();
    check("stall_reads_ft", reads[0], 2);
    check("stall_reads_nf", reads[1], 2);
    out_ready = 1'b1;
    wait_idle(40, 1'b0);

    // FIFO empty flag toggling every cycle.
    repeat (4) push($urandom());
    start = 1'b1; len = 4; tick(); start = 1'b0;
    wait_idle(60, 1'b1);

    // Zero-length burst.
    start = 1'b1; len = 0; tick(); start = 1'b0;
    wait_idle(10, 1'b0);

    // Start while a burst runs is ignored; extra FIFO words must stay unread.
    repeat (8) push($urandom());
    start = 1'b1; len = 3; tick();
    len = 5; tick(); start = 1'b0;
    wait_idle(40, 1'b0);

    // Reset after two words of a four-word burst, then a clean two-word burst.
    repeat (4) push($urandom());
    start = 1'b1; len = 4; tick(); start = 1'b0;
    for (int k = 0; k < 20 && deliv[0] < 2; k++) tick();
    check("mid_burst_reach", deliv[0] >= 2, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    repeat (2) push($urandom());
    start = 1'b1; len = 2; tick(); start = 1'b0;
    wait_idle(40, 1'b0);

    // Random bursts with random backpressure, empty gaps and stray starts.
    for (int b = 0; b < 25; b++) begin
      int unsigned l;
      l = $urandom_range(0, 6);
      repeat (l) push($urandom());
      start = 1'b1; len = LW'(l); out_ready = 1'($urandom_range(0, 1)); tick();
      start = 1'b0;
      for (int k = 0; k < 200 && !all_idle(); k++) begin
        out_ready   = ($urandom_range(0, 3) != 0);
        force_empty = ($urandom_range(0, 3) == 0);
        if (active[0] && active[1] && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          len   = LW'($urandom_range(1, 6));
        end
        tick();
        start = 1'b0;
      end
      check("rand_idle", all_idle(), 1);
      force_empty = 1'b0;
      out_ready   = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
